// File: rtl/pll_mon_pkg.sv
// Shared constants for the PLL lock monitor: state encoding, LED polarity
// and the loss counter ceiling.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_QUALIFY   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } pll_state_e;

  localparam logic       LED_ON   = 1'b0;
  localparam logic       LED_OFF  = 1'b1;
  localparam logic [7:0] LOSS_MAX = 8'd255;

  // Saturating increment used by the lock-loss counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == LOSS_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pll_lock_monitor_if.sv
// Status bundle of the PLL lock monitor: the lock input plus every status output.
// The monitor side is master; whatever consumes the status is slave.
interface pll_lock_monitor_if;
  logic       locked;
  logic       rst_out;
  logic       ready;
  logic [7:0] loss_count;
  logic       rgb_led0_r;
  logic       rgb_led0_g;
  logic       rgb_led0_b;

  modport master (
    input  locked,
    output rst_out, ready, loss_count, rgb_led0_r, rgb_led0_g, rgb_led0_b
  );

  modport slave (
    output locked,
    input  rst_out, ready, loss_count, rgb_led0_r, rgb_led0_g, rgb_led0_b
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// It clears synchronously on rst.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture stage followed by resolve stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies the PLL lock flag, holds downstream logic in reset until lock has
// been stable long enough, and counts lock losses while the system is running.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 48000,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       locked,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] loss_count,
  output logic       rgb_led0_r,
  output logic       rgb_led0_g,
  output logic       rgb_led0_b
);

  localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             locked_s;
  pll_state_e       state_r;
  pll_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [7:0]       loss_r;
  logic [7:0]       loss_nxt_s;
  logic             rst_out_r;
  logic             ready_r;
  logic             led_r_r;
  logic             led_g_r;
  logic             led_b_r;

  sync2 u_sync2 (
    .clk (clk48),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state logic; a loss always beats a terminal count.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    loss_nxt_s  = loss_r;
    case (state_r)
      ST_WAIT_LOCK: begin
        cnt_nxt_s = CNT_ZERO;
        if (locked_s) begin
          state_nxt_s = ST_QUALIFY;
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_QUALIFY: begin
        if (!locked_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_TERM) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == HOLD_TERM) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        cnt_nxt_s = CNT_ZERO;
        if (!locked_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          loss_nxt_s  = sat_inc8(loss_r);
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT_LOCK;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and status flops; outputs are registered copies of the
  // decoded next state so they switch on the same edge as the state, glitch-free.
  always_ff @(posedge clk48) begin
    if (rst) begin
      state_r   <= ST_WAIT_LOCK;
      cnt_r     <= CNT_ZERO;
      loss_r    <= 8'd0;
      rst_out_r <= 1'b1;
      ready_r   <= 1'b0;
      led_r_r   <= LED_OFF;
      led_g_r   <= LED_OFF;
      led_b_r   <= LED_OFF;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      loss_r    <= loss_nxt_s;
      rst_out_r <= (state_nxt_s != ST_RUN);
      ready_r   <= (state_nxt_s == ST_RUN);
      led_r_r   <= (loss_nxt_s != 8'd0) ? LED_ON : LED_OFF;
      led_g_r   <= (state_nxt_s == ST_RUN) ? LED_ON : LED_OFF;
      led_b_r   <= ((state_nxt_s == ST_QUALIFY) || (state_nxt_s == ST_HOLD)) ? LED_ON : LED_OFF;
    end
  end

  assign rst_out    = rst_out_r;
  assign ready      = ready_r;
  assign loss_count = loss_r;
  assign rgb_led0_r = led_r_r;
  assign rgb_led0_g = led_g_r;
  assign rgb_led0_b = led_b_r;

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 48000, giving the consecutive synchronized-lock cycles required before release (1 ms at 48 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, giving the reset-extension cycles after qualification.
REQ-003 SHALL have parameter CNT_W, default 16, giving the qualify/hold counter width; it SHALL hold max(STABLE_CYCLES, HOLD_CYCLES).
REQ-004 SHALL have port clk48, input, 1 bit: sole clock, 48 MHz.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port locked, input, 1 bit: PLL lock flag, asynchronous to clk48.
REQ-007 SHALL have port rst_out, output, 1 bit: downstream reset for PLL-clocked logic, active-high.
REQ-008 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-009 SHALL have port loss_count, output, 8 bits: saturating count of lock losses in RUN.
REQ-010 SHALL have ports rgb_led0_r, rgb_led0_g and rgb_led0_b, outputs, 1 bit each: status LEDs, active-low (0 = lit).

Function
REQ-011 SHALL pass locked through a two-flop synchronizer to form locked_s; locked sampled at edge 0 is visible as locked_s after edge 1.
REQ-012 SHALL implement states WAIT_LOCK, QUALIFY, HOLD and RUN, held in a registered state.
REQ-013 WAIT_LOCK SHALL go to QUALIFY at the first edge with locked_s=1 and SHALL clear the counter.
REQ-014 QUALIFY SHALL last exactly STABLE_CYCLES cycles with locked_s=1, then go to HOLD with the counter cleared.
REQ-015 HOLD SHALL last exactly HOLD_CYCLES cycles with locked_s=1, then go to RUN.
REQ-016 locked_s=0 in QUALIFY or HOLD SHALL return the block to WAIT_LOCK at the next edge, clear the counter and leave loss_count unchanged.
REQ-017 locked_s=0 in RUN SHALL return the block to WAIT_LOCK at the next edge and increment loss_count, saturating at 255.
REQ-018 Total release latency: ready and rst_out SHALL change at edge 2+STABLE_CYCLES+HOLD_CYCLES, counting the first high sample of locked as edge 0.
REQ-019 rst_out SHALL be 1 in every state except RUN; ready SHALL equal NOT rst_out; both SHALL be decoded from the state register only (Moore).
REQ-020 rst_out SHALL assert at the same edge that state leaves RUN (2-3 cycles after the locked fall), with no glitch.
REQ-021 rgb_led0_g SHALL be lit in RUN only.
REQ-022 rgb_led0_b SHALL be lit in QUALIFY and HOLD only.
REQ-023 rgb_led0_r SHALL be lit whenever loss_count != 0 (sticky fault indicator).
REQ-024 A locked glitch shorter than one cycle that misses both synchronizer samples SHALL have no effect; any glitch captured by the synchronizer SHALL be treated as a loss.
REQ-025 The counter SHALL never wrap: it is cleared on each state entry and compared against its terminal value.
REQ-026 If locked_s falls on the same edge that the QUALIFY or HOLD terminal count is reached, the loss SHALL win and the next state SHALL be WAIT_LOCK.

Reset
REQ-027 rst=1 at an edge SHALL force state WAIT_LOCK, counter 0, both synchronizer flops 0, loss_count 0, rst_out 1, ready 0 and all LEDs unlit (1).
REQ-028 rst SHALL override all transitions, including mid-QUALIFY and in RUN; a reset taken in RUN SHALL NOT count as a lock loss.
REQ-029 After rst is released, normal qualification SHALL restart from WAIT_LOCK.

Structure
REQ-030 Package pll_mon_pkg SHALL hold the state encoding constants, LED_ON=1'b0, and the LOSS_MAX=255 constant.
REQ-031 The synchronizer SHALL be a separate sub-module named sync2 (parameterless, 1 bit), reusable elsewhere.
REQ-032 All other logic SHALL be in pll_lock_monitor.

Verification (STABLE_CYCLES=8, HOLD_CYCLES=4)
REQ-033 Scenario 1: locked rises before edge 0 and is held -> QUALIFY from edge 2, HOLD at edge 10, ready=1 and rst_out=0 at edge 14, green lit, blue unlit.
REQ-034 Scenario 2: locked low at edge 6 (QUALIFY), high again afterwards -> WAIT_LOCK, loss_count=0, full 8+4 requalification, ready only after 12 further stable cycles.
REQ-035 Scenario 3: in RUN, locked dropped for 3 cycles -> rst_out=1 within 3 edges, loss_count=1, red lit, re-release 14 edges after locked returns.
REQ-036 Scenario 4: 260 RUN-loss cycles -> loss_count stays at 255, no wrap.
REQ-037 Scenario 5: rst=1 for 1 cycle while in RUN with loss_count=5 -> next cycle WAIT_LOCK, loss_count=0, rst_out=1, all LEDs unlit.
REQ-038 Scenario 6: locked falls so that locked_s drops on the HOLD terminal edge -> state WAIT_LOCK, ready never pulses.
